mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequencer that shares the single 64-bit data memory port between the instruction-fetch requester and the load/store requester of the multicycle RISC-V datapath. It sits between the control unit's fetch/memory requests and the memory. It grants one requester at a time and holds the address for the memory's fixed read latency. It registers the read data and returns a one-cycle acknowledge. On contention the two requesters alternate, so neither can starve the other.

## Interface
Parameters:
- MEM_LAT, 2, cycles from address presentation to valid MemRdata; legal 1..8
- DATA_W, 64, data and address width

Ports:
- Clk  in  1  clock, all state updates on rising edge
- Reset  in  1  asynchronous, active-low reset
- IReq  in  1  instruction-fetch read request, level
- IAddr  in  64  fetch address, stable while IReq high
- IAck  out  1  one-cycle pulse, fetch complete, RData valid
- DReq  in  1  data request, level
- DWr  in  1  1 = store, 0 = load; stable while DReq high
- DAddr  in  64  data address, stable while DReq high
- DWdata  in  64  store data, stable while DReq high
- DAck  out  1  one-cycle pulse, data access complete
- RData  out  64  registered read data, holds until next read capture
- MemEn  out  1  memory access active
- MemWr  out  1  memory write strobe
- MemAddr  out  64  memory address
- MemWdata  out  64  memory write data
- MemRdata  in  64  memory read data, valid MEM_LAT cycles after address
- Busy  out  1  transaction in progress (state != IDLE)
- Owner  out  1  current/last grant: 0 = instruction, 1 = data

## Operation
- Requests are level-sensitive. A requester holds Req, Addr, Wr and Wdata stable until its Ack. It drops Req in the Ack cycle.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: if no Req, stay. Otherwise pick a winner, latch its address, write flag and write data into internal registers, load the latency counter, and go to BUSY.
  - BUSY (read): last for MEM_LAT cycles. In the final BUSY cycle, capture MemRdata into RData, then go to DONE.
  - BUSY (write): last exactly 1 cycle with MemWr=1, then go to DONE. RData is unchanged.
  - DONE: pulse the Ack of the granted side for one cycle. Ignore Req. Go to IDLE.
- Arbitration in IDLE:
  - If only one Req is high, that requester wins.
  - If both are high, the side that did not win the previous grant wins. The last-winner flag LastD resets to 0, so the first contention goes to data.
- Memory side: MemEn=1 and MemAddr=latched address throughout BUSY. MemWdata=latched write data. All three are 0 outside BUSY.
- Owner updates on grant and holds through IDLE.
- A Req that drops during BUSY does not abort the transaction. Its Ack is still pulsed and the requester ignores it.
- Counter width is $clog2(MEM_LAT+1). No wrap: the counter is reloaded only in IDLE.

## Timing
- Reset low forces immediately: state IDLE, IAck=DAck=0, RData=0, MemEn=MemWr=0, MemAddr=MemWdata=0, Busy=0, Owner=0, LastD=0, counter=0.
- Reset mid-transaction abandons the access with no Ack. Requesters must re-request after reset.
- Read latency: Req sampled high at edge t. BUSY covers cycles t..t+MEM_LAT-1. Ack and valid RData appear in cycle t+MEM_LAT. IDLE resumes at t+MEM_LAT+1.
- Write latency: Req sampled at edge t. MemWr is high for cycle t. Ack is high in cycle t+1.
- Back-to-back: the earliest next grant is sampled at the edge ending the first IDLE cycle after DONE. The minimum gap is one IDLE cycle.
- Simultaneous IReq/DReq in IDLE: exactly one is granted. The loser keeps Req high and is granted on the next IDLE evaluation.
- All outputs are registered or decoded from state only. There is no combinational path from Req to any output.

## Test plan
- Reset while DReq=1, DWr=0 in BUSY (MEM_LAT=2) -> all outputs 0 at once. After release with DReq held, the read restarts and DAck arrives 3 cycles after the first sampling edge.
- Single fetch, IAddr=0x40, MemRdata returns 0x00000013_00A00093 at latency 2 -> MemEn high 2 cycles with MemAddr=0x40. IAck is a 1-cycle pulse with RData=0x00000013_00A00093 and Owner=0.
- Store DAddr=0x80, DWdata=0xDEADBEEF_CAFEF00D -> MemWr high exactly 1 cycle with MemAddr=0x80. DAck follows the next cycle and RData is unchanged.
- IReq and DReq raised together and held, three times in sequence -> grant order D, I, D. Each Ack arrives MEM_LAT+1 cycles after its grant edge, with a one-IDLE-cycle gap between grants.
- DReq dropped during BUSY -> DAck still pulses once, then the FSM returns to IDLE with Busy=0.
- MEM_LAT=1 and MEM_LAT=8 builds, single reads -> Ack 2 and 9 cycles after the sampling edge, with MemEn high 1 and 8 cycles respectively.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the instruction-fetch and
// load/store requesters. One grant at a time, address held for the fixed read
// latency, read data registered, one-cycle acknowledge to the granted side.
// Under contention the side that did not win last time gets the port.
module mem_port_arbiter #(
   parameter int MEM_LAT = 2,
   parameter int DATA_W  = 64
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              IReq,
   input  logic [DATA_W-1:0] IAddr,
   output logic              IAck,
   input  logic              DReq,
   input  logic              DWr,
   input  logic [DATA_W-1:0] DAddr,
   input  logic [DATA_W-1:0] DWdata,
   output logic              DAck,
   output logic [DATA_W-1:0] RData,
   output logic              MemEn,
   output logic              MemWr,
   output logic [DATA_W-1:0] MemAddr,
   output logic [DATA_W-1:0] MemWdata,
   input  logic [DATA_W-1:0] MemRdata,
   output logic              Busy,
   output logic              Owner
);

   localparam int CNT_W = $clog2(MEM_LAT + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0]  addr_q, addr_d;
   logic [DATA_W-1:0]  wdata_q, wdata_d;
   logic               wr_q, wr_d;
   // Owner doubles as the last-winner flag: both change only on a grant and
   // both reset to instruction, so the first contention goes to data.
   logic               owner_q, owner_d;
   logic [DATA_W-1:0]  rdata_q, rdata_d;
   logic               win_d;

   // State and datapath registers; everything clears on reset.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
         owner_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wr_q    <= wr_d;
         owner_q <= owner_d;
         rdata_q <= rdata_d;
      end
   end

   // Next-state: arbitrate and latch in IDLE, count down in BUSY, ack in DONE.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wr_d    = wr_q;
      owner_d = owner_q;
      rdata_d = rdata_q;
      win_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (IReq || DReq) begin
               // Data wins if it is alone, or if instruction won last time.
               win_d   = DReq && (!IReq || !owner_q);
               owner_d = win_d;
               addr_d  = win_d ? DAddr : IAddr;
               wr_d    = win_d && DWr;
               wdata_d = win_d ? DWdata : '0;
               // A store occupies the port for one cycle; a read for MEM_LAT.
               cnt_d   = (win_d && DWr) ? CNT_W'(1) : CNT_W'(MEM_LAT);
               state_d = BUSY;
            end
         end
         BUSY: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               if (!wr_q) begin
                  rdata_d = MemRdata;
               end
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs are decoded from registered state only; no path from the requests.
   assign Busy     = (state_q != IDLE);
   assign MemEn    = (state_q == BUSY);
   assign MemWr    = (state_q == BUSY) && wr_q;
   assign MemAddr  = (state_q == BUSY) ? addr_q : '0;
   assign MemWdata = (state_q == BUSY) ? wdata_q : '0;
   assign IAck     = (state_q == DONE) && !owner_q;
   assign DAck     = (state_q == DONE) && owner_q;
   assign RData    = rdata_q;
   assign Owner    = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed and random rounds on a MEM_LAT=2
// instance against a transaction-level schedule model, plus latency checks on
// MEM_LAT=1 and MEM_LAT=8 instances.
module tb_mem_port_arbiter;

   localparam int LAT = 2;
   localparam logic [63:0] XVAL = 64'hA5A5_0001_5A5A_0008;
   localparam logic [63:0] BAD  = 64'hBAD0_0BAD_BAD0_0BAD;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        IReq, DReq, DWr;
   logic [63:0] IAddr, DAddr, DWdata;
   logic        IAck, DAck, MemEn, MemWr, Busy, Owner;
   logic [63:0] RData, MemAddr, MemWdata, MemRdata;

   int checks = 0;
   int failures = 0;

   always #5 Clk = ~Clk;

   mem_port_arbiter #(.MEM_LAT(LAT), .DATA_W(64)) dut (
      .Clk(Clk), .Reset(Reset),
      .IReq(IReq), .IAddr(IAddr), .IAck(IAck),
      .DReq(DReq), .DWr(DWr), .DAddr(DAddr), .DWdata(DWdata), .DAck(DAck),
      .RData(RData), .MemEn(MemEn), .MemWr(MemWr), .MemAddr(MemAddr),
      .MemWdata(MemWdata), .MemRdata(MemRdata), .Busy(Busy), .Owner(Owner)
   );

   // Default memory content; word 8 (address 0x40) holds the fetch pattern.
   function automatic logic [63:0] memval(input logic [4:0] idx);
      if (idx == 5'd8) return 64'h00000013_00A00093;
      return {27'h0C0DE00, idx, 27'h1234560, idx};
   endfunction

   // Environment memory: stored as difference from default so it starts at zero.
   logic [63:0] env_mem [32] = '{default: 64'h0};
   int en_cnt;
   always @(posedge Clk or negedge Reset) begin
      if (!Reset) en_cnt <= 0;
      else if (MemEn) en_cnt <= en_cnt + 1;
      else en_cnt <= 0;
   end
   always @(posedge Clk) begin
      if (MemEn && MemWr) env_mem[MemAddr[7:3]] <= MemWdata ^ memval(MemAddr[7:3]);
   end
   assign MemRdata = (MemEn && en_cnt == LAT - 1) ?
                     (env_mem[MemAddr[7:3]] ^ memval(MemAddr[7:3])) : BAD;

   // Extra instances for the latency extremes.
   logic [1:0]       x_dreq = 2'b00;
   logic [63:0]      x_daddr = 64'h18;
   logic [1:0]       x_iack, x_dack, x_memen, x_memwr, x_busy, x_owner;
   logic [1:0][63:0] x_rdata, x_maddr, x_mwd, x_mrd;
   int cnt1, cnt8;

   mem_port_arbiter #(.MEM_LAT(1), .DATA_W(64)) u_lat1 (
      .Clk(Clk), .Reset(Reset),
      .IReq(1'b0), .IAddr(64'h0), .IAck(x_iack[0]),
      .DReq(x_dreq[0]), .DWr(1'b0), .DAddr(x_daddr), .DWdata(64'h0), .DAck(x_dack[0]),
      .RData(x_rdata[0]), .MemEn(x_memen[0]), .MemWr(x_memwr[0]), .MemAddr(x_maddr[0]),
      .MemWdata(x_mwd[0]), .MemRdata(x_mrd[0]), .Busy(x_busy[0]), .Owner(x_owner[0])
   );
   mem_port_arbiter #(.MEM_LAT(8), .DATA_W(64)) u_lat8 (
      .Clk(Clk), .Reset(Reset),
      .IReq(1'b0), .IAddr(64'h0), .IAck(x_iack[1]),
      .DReq(x_dreq[1]), .DWr(1'b0), .DAddr(x_daddr), .DWdata(64'h0), .DAck(x_dack[1]),
      .RData(x_rdata[1]), .MemEn(x_memen[1]), .MemWr(x_memwr[1]), .MemAddr(x_maddr[1]),
      .MemWdata(x_mwd[1]), .MemRdata(x_mrd[1]), .Busy(x_busy[1]), .Owner(x_owner[1])
   );

   always @(posedge Clk) begin
      cnt1 <= x_memen[0] ? cnt1 + 1 : 0;
      cnt8 <= x_memen[1] ? cnt8 + 1 : 0;
   end
   assign x_mrd[0] = (x_memen[0] && cnt1 == 0) ? XVAL : BAD;
   assign x_mrd[1] = (x_memen[1] && cnt8 == 7) ? XVAL : BAD;

   // Reference model state
   logic [63:0] ref_mem [32];
   bit          m_lastd;
   bit          m_owner;
   logic [63:0] m_rd;
   int          round_no = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One round: requests raised now (DUT idle), checked cycle by cycle against
   // a schedule derived from the arbitration and latency rules.
   task automatic do_round(input bit i_on, input bit d_on, input bit d_wr, input bit d_drop,
                           input logic [63:0] ia, input logic [63:0] da, input logic [63:0] dw);
      logic        e_en [32], e_wr [32], e_busy [32], e_ia [32], e_da [32], e_own [32];
      logic [63:0] e_addr [32], e_wd [32], e_rd [32];
      bit pi, pd;
      int t, endc, iack_c, dack_c, dst_c;
      round_no++;
      IReq = i_on; IAddr = ia; DReq = d_on; DWr = d_wr; DAddr = da; DWdata = dw;
      pi = i_on; pd = d_on; t = 0; endc = 1; iack_c = -1; dack_c = -1; dst_c = -1;
      for (int c = 0; c < 32; c++) begin
         e_en[c] = 0; e_wr[c] = 0; e_busy[c] = 0; e_ia[c] = 0; e_da[c] = 0;
         e_addr[c] = '0; e_wd[c] = '0; e_own[c] = m_owner; e_rd[c] = m_rd;
      end
      while (pi || pd) begin
         bit w;
         int len;
         logic [63:0] a;
         w = pd && (!pi || !m_lastd);
         m_lastd = w;
         len = (w && d_wr) ? 1 : LAT;
         a = w ? da : ia;
         for (int c = t; c < t + len; c++) begin
            e_en[c] = 1; e_wr[c] = w && d_wr; e_addr[c] = a;
            e_wd[c] = w ? dw : 64'h0; e_busy[c] = 1;
         end
         e_busy[t + len] = 1;
         for (int c = t; c < 32; c++) e_own[c] = w;
         if (w) begin e_da[t + len] = 1; dack_c = t + len; dst_c = t; pd = 0; end
         else begin e_ia[t + len] = 1; iack_c = t + len; pi = 0; end
         if (w && d_wr) ref_mem[a[7:3]] = dw;
         else for (int c = t + len; c < 32; c++) e_rd[c] = ref_mem[a[7:3]];
         endc = t + len + 1;
         t = t + len + 2;
      end
      m_owner = e_own[31];
      m_rd = e_rd[31];
      for (int c = 0; c <= endc; c++) begin
         @(posedge Clk);
         @(negedge Clk);
         chk($sformatf("r%0d c%0d MemEn", round_no, c), MemEn, e_en[c]);
         chk($sformatf("r%0d c%0d MemWr", round_no, c), MemWr, e_wr[c]);
         chk($sformatf("r%0d c%0d MemAddr", round_no, c), MemAddr, e_addr[c]);
         chk($sformatf("r%0d c%0d MemWdata", round_no, c), MemWdata, e_wd[c]);
         chk($sformatf("r%0d c%0d Busy", round_no, c), Busy, e_busy[c]);
         chk($sformatf("r%0d c%0d IAck", round_no, c), IAck, e_ia[c]);
         chk($sformatf("r%0d c%0d DAck", round_no, c), DAck, e_da[c]);
         chk($sformatf("r%0d c%0d Owner", round_no, c), Owner, e_own[c]);
         chk($sformatf("r%0d c%0d RData", round_no, c), RData, e_rd[c]);
         if (c == iack_c) IReq = 0;
         if (c == dack_c) DReq = 0;
         if (d_drop && c == dst_c) DReq = 0;
      end
   endtask

   // Single read on one of the latency-extreme instances.
   task automatic lat_check(input int k, input int len);
      int en_seen;
      en_seen = 0;
      x_dreq[k] = 1'b1;
      for (int c = 0; c <= len + 1; c++) begin
         @(posedge Clk);
         @(negedge Clk);
         if (x_memen[k]) en_seen++;
         chk($sformatf("lat%0d c%0d MemEn", len, c), x_memen[k], (c < len) ? 64'd1 : 64'd0);
         chk($sformatf("lat%0d c%0d DAck", len, c), x_dack[k], (c == len) ? 64'd1 : 64'd0);
         if (c == len) begin
            chk($sformatf("lat%0d RData", len), x_rdata[k], XVAL);
            x_dreq[k] = 1'b0;
         end
      end
      chk($sformatf("lat%0d MemEn cycles", len), 64'(en_seen), 64'(len));
   endtask

   initial begin
      IReq = 0; DReq = 0; DWr = 0; IAddr = '0; DAddr = '0; DWdata = '0;
      m_lastd = 0; m_owner = 0; m_rd = '0;
      for (int i = 0; i < 32; i++) ref_mem[i] = memval(5'(i));
      Reset = 1'b1;
      #1 Reset = 1'b0;
      #1;
      chk("rst MemEn", MemEn, 0);
      chk("rst Busy", Busy, 0);
      chk("rst IAck", IAck, 0);
      chk("rst DAck", DAck, 0);
      chk("rst RData", RData, 0);
      chk("rst Owner", Owner, 0);
      chk("rst MemAddr", MemAddr, 0);
      repeat (2) @(negedge Clk);
      Reset = 1'b1;

      // Single fetch from 0x40
      do_round(1, 0, 0, 0, 64'h40, 64'h0, 64'h0);
      chk("fetch RData", RData, 64'h00000013_00A00093);
      // Single store to 0x80, then load it back
      do_round(0, 1, 1, 0, 64'h0, 64'h80, 64'hDEADBEEF_CAFEF00D);
      do_round(0, 1, 0, 0, 64'h0, 64'h80, 64'h0);
      chk("store readback", RData, 64'hDEADBEEF_CAFEF00D);
      // Three contentions in a row
      for (int k = 0; k < 3; k++)
         do_round(1, 1, 0, 0, 64'(k * 8), 64'(k * 8 + 64), 64'h0);
      // Data request dropped while the access is in flight
      do_round(0, 1, 0, 1, 64'h0, 64'h28, 64'h0);

      // Reset in the middle of a data read
      @(negedge Clk);
      DReq = 1; DWr = 0; DAddr = 64'h18;
      @(posedge Clk);
      #2 Reset = 1'b0;
      #1;
      chk("midrst MemEn", MemEn, 0);
      chk("midrst Busy", Busy, 0);
      chk("midrst DAck", DAck, 0);
      chk("midrst MemAddr", MemAddr, 0);
      chk("midrst RData", RData, 0);
      chk("midrst Owner", Owner, 0);
      m_lastd = 0; m_owner = 0; m_rd = '0;
      @(negedge Clk);
      Reset = 1'b1;
      do_round(0, 1, 0, 0, 64'h0, 64'h18, 64'h0);

      // Random rounds
      for (int r = 0; r < 40; r++) begin
         do_round(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  {56'h0, 5'($urandom_range(0, 31)), 3'b000},
                  {56'h0, 5'($urandom_range(0, 31)), 3'b000},
                  {$urandom, $urandom});
      end

      // Latency extremes
      @(negedge Clk);
      lat_check(0, 1);
      lat_check(1, 8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
